// File: rtl/issue_dispatch_unit_if.sv
// Fetch, ROB, reservation-station and commit signals of the issue stage.
// The slave view belongs to the issue stage and the master view to its environment.
interface issue_dispatch_unit_if #(
    parameter int ROB_TAG_W = 3,
    parameter int IQ_DEPTH  = 4
);
    localparam int SRC_W = (ROB_TAG_W > 4) ? ROB_TAG_W : 4;
    localparam int CNT_W = $clog2(IQ_DEPTH) + 1;

    logic                 flush;
    logic                 inst_valid;
    logic                 inst_ready;
    logic [15:0]          inst_data;
    logic                 rob_ready;
    logic [ROB_TAG_W-1:0] rob_tail;
    logic                 rob_alloc;
    logic [3:0]           rob_op;
    logic [3:0]           rob_rd;
    logic [1:0]           rs_ready;
    logic [1:0]           rs_dispatch;
    logic [3:0]           rs_op;
    logic [ROB_TAG_W-1:0] rs_dest_tag;
    logic                 rs_src1_is_reg;
    logic [SRC_W-1:0]     rs_src1;
    logic                 rs_src2_is_reg;
    logic [SRC_W-1:0]     rs_src2;
    logic                 commit_valid;
    logic [3:0]           commit_rd;
    logic [ROB_TAG_W-1:0] commit_tag;
    logic                 bad_op;
    logic [CNT_W-1:0]     iq_count;

    modport slave (
        input  flush, inst_valid, inst_data,
        input  rob_ready, rob_tail, rs_ready,
        input  commit_valid, commit_rd, commit_tag,
        output inst_ready, rob_alloc, rob_op, rob_rd,
        output rs_dispatch, rs_op, rs_dest_tag,
        output rs_src1_is_reg, rs_src1,
        output rs_src2_is_reg, rs_src2,
        output bad_op, iq_count
    );

    modport master (
        output flush, inst_valid, inst_data,
        output rob_ready, rob_tail, rs_ready,
        output commit_valid, commit_rd, commit_tag,
        input  inst_ready, rob_alloc, rob_op, rob_rd,
        input  rs_dispatch, rs_op, rs_dest_tag,
        input  rs_src1_is_reg, rs_src1,
        input  rs_src2_is_reg, rs_src2,
        input  bad_op, iq_count
    );
endinterface

// File: rtl/issue_dispatch_unit.sv
// In-order issue stage: instruction queue, rename table and single-issue
// dispatch to the add/sub or mul/div reservation stations.
module issue_dispatch_unit #(
    parameter int IQ_DEPTH  = 4,
    parameter int ROB_TAG_W = 3,
    parameter int NUM_REGS  = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    issue_dispatch_unit_if.slave bus
);
    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SRC_W = (ROB_TAG_W > 4) ? ROB_TAG_W : 4;
    localparam logic [CNT_W-1:0] IQ_FULL = CNT_W'(IQ_DEPTH);

    logic [15:0]          iq_q [IQ_DEPTH];
    logic [15:0]          iq_d [IQ_DEPTH];
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [NUM_REGS-1:0]  reg_valid_q, reg_valid_d;
    logic [ROB_TAG_W-1:0] reg_tag_q [NUM_REGS];
    logic [ROB_TAG_W-1:0] reg_tag_d [NUM_REGS];

    logic [15:0] head_inst;
    logic [3:0]  op, rd, rs1, rs2;
    logic        nonempty, op_ok, cls;
    logic        fire, bad, pop, push, iq_ready;
    logic        s1_rdy, s2_rdy;

    always_comb begin
        head_inst = iq_q[head_q];
        op        = head_inst[15:12];
        rd        = head_inst[11:8];
        rs1       = head_inst[7:4];
        rs2       = head_inst[3:0];
        nonempty  = (count_q != '0);
        op_ok     = (op[3:2] == 2'b00);
        cls       = op[1];
        iq_ready  = !bus.flush && (count_q < IQ_FULL);
        push      = bus.inst_valid && iq_ready;
        fire      = nonempty && !bus.flush && op_ok
                    && bus.rob_ready && bus.rs_ready[cls];
        bad       = nonempty && !bus.flush && !op_ok;
        pop       = fire || bad;
    end

    // A retiring tag is forwarded so the source need not wait a cycle.
    always_comb begin
        s1_rdy = reg_valid_q[rs1]
                 || (bus.commit_valid && reg_tag_q[rs1] == bus.commit_tag);
        s2_rdy = reg_valid_q[rs2]
                 || (bus.commit_valid && reg_tag_q[rs2] == bus.commit_tag);
    end

    always_comb begin
        bus.inst_ready     = iq_ready;
        bus.rob_alloc      = fire;
        bus.rob_op         = fire ? op : '0;
        bus.rob_rd         = fire ? rd : '0;
        bus.rs_dispatch    = !fire ? 2'b00 : (cls ? 2'b10 : 2'b01);
        bus.rs_op          = fire ? op : '0;
        bus.rs_dest_tag    = fire ? bus.rob_tail : '0;
        bus.rs_src1_is_reg = fire && s1_rdy;
        bus.rs_src2_is_reg = fire && s2_rdy;
        bus.rs_src1        = '0;
        bus.rs_src2        = '0;
        if (fire) begin
            bus.rs_src1 = s1_rdy ? SRC_W'(rs1) : SRC_W'(reg_tag_q[rs1]);
            bus.rs_src2 = s2_rdy ? SRC_W'(rs2) : SRC_W'(reg_tag_q[rs2]);
        end
        bus.bad_op         = bad;
        bus.iq_count       = count_q;
    end

    always_comb begin
        iq_d        = iq_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        reg_valid_d = reg_valid_q;
        reg_tag_d   = reg_tag_q;
        if (bus.flush) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            reg_valid_d = '1;
        end else begin
            if (push) begin
                iq_d[tail_q] = bus.inst_data;
                tail_d       = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (bus.commit_valid
                && reg_tag_q[bus.commit_rd] == bus.commit_tag) begin
                reg_valid_d[bus.commit_rd] = 1'b1;
            end
            // Rename after commit so a same-edge rename of rd wins.
            if (fire) begin
                reg_valid_d[rd] = 1'b0;
                reg_tag_d[rd]   = bus.rob_tail;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                iq_q[i] <= '0;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_tag_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            reg_valid_q <= '1;
        end else begin
            iq_q        <= iq_d;
            reg_tag_q   <= reg_tag_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            reg_valid_q <= reg_valid_d;
        end
    end
endmodule

// File: tb/tb_issue_dispatch_unit.sv
// Bench for issue_dispatch_unit: directed vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_issue_dispatch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    issue_dispatch_unit_if #(.ROB_TAG_W(3), .IQ_DEPTH(4)) bif();

    issue_dispatch_unit #(
        .IQ_DEPTH(4), .ROB_TAG_W(3), .NUM_REGS(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: program-order queue plus per-register pending tag.
    logic [15:0] mq[$];
    bit          busy [16];
    logic [2:0]  mtag [16];

    logic       e_ready, e_alloc, e_bad, e_s1r, e_s2r;
    logic [1:0] e_disp;
    logic [3:0] e_op, e_rd, e_s1, e_s2;
    logic [2:0] e_tag;
    int         e_cnt;

    typedef struct {
        logic        iv;
        logic [15:0] data;
        logic        rr;
        logic [2:0]  tail;
        logic [1:0]  rs;
        logic        cv;
        logic [3:0]  crd;
        logic [2:0]  ctag;
        logic [1:0]  x_disp;
        logic        x_s1r;
        logic [3:0]  x_s1;
        logic        x_s2r;
        logic [3:0]  x_s2;
        logic [2:0]  x_dtag;
        logic        x_bad;
        int          x_cnt;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 16; i++) begin
            busy[i] = 1'b0;
            mtag[i] = 3'd0;
        end
    endtask

    task automatic src_exp(input logic [3:0] s, output logic r,
                           output logic [3:0] v);
        if (!busy[s] || (bif.commit_valid && mtag[s] == bif.commit_tag)) begin
            r = 1'b1;
            v = s;
        end else begin
            r = 1'b0;
            v = {1'b0, mtag[s]};
        end
    endtask

    task automatic compute_exp();
        logic [15:0] h;
        int cls;
        e_ready = 0; e_alloc = 0; e_bad = 0; e_s1r = 0; e_s2r = 0;
        e_disp = 0; e_op = 0; e_rd = 0; e_s1 = 0; e_s2 = 0; e_tag = 0;
        e_cnt = mq.size();
        e_ready = !bif.flush && (mq.size() < 4);
        if (!bif.flush && mq.size() > 0) begin
            h = mq[0];
            if (h[15:12] > 4'd3) begin
                e_bad = 1'b1;
            end else begin
                cls = (h[15:12] >= 4'd2) ? 1 : 0;
                if (bif.rob_ready && bif.rs_ready[cls]) begin
                    e_alloc = 1'b1;
                    e_disp  = (cls == 1) ? 2'b10 : 2'b01;
                    e_op    = h[15:12];
                    e_rd    = h[11:8];
                    e_tag   = bif.rob_tail;
                    src_exp(h[7:4], e_s1r, e_s1);
                    src_exp(h[3:0], e_s2r, e_s2);
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("inst_ready", 32'(bif.inst_ready), 32'(e_ready));
        chk("rob_alloc", 32'(bif.rob_alloc), 32'(e_alloc));
        chk("rob_op", 32'(bif.rob_op), 32'(e_op));
        chk("rob_rd", 32'(bif.rob_rd), 32'(e_rd));
        chk("rs_dispatch", 32'(bif.rs_dispatch), 32'(e_disp));
        chk("rs_op", 32'(bif.rs_op), 32'(e_op));
        chk("rs_dest_tag", 32'(bif.rs_dest_tag), 32'(e_tag));
        chk("src1_is_reg", 32'(bif.rs_src1_is_reg), 32'(e_s1r));
        chk("src1", 32'(bif.rs_src1), 32'(e_s1));
        chk("src2_is_reg", 32'(bif.rs_src2_is_reg), 32'(e_s2r));
        chk("src2", 32'(bif.rs_src2), 32'(e_s2));
        chk("bad_op", 32'(bif.bad_op), 32'(e_bad));
        chk("iq_count", 32'(bif.iq_count), 32'(e_cnt));
    endtask

    task automatic model_update();
        if (bif.flush) begin
            mq.delete();
            for (int i = 0; i < 16; i++) busy[i] = 1'b0;
        end else begin
            if (e_alloc || e_bad) void'(mq.pop_front());
            if (bif.inst_valid && e_ready) mq.push_back(bif.inst_data);
            if (bif.commit_valid && mtag[bif.commit_rd] == bif.commit_tag)
                busy[bif.commit_rd] = 1'b0;
            if (e_alloc) begin
                busy[e_rd] = 1'b1;
                mtag[e_rd] = bif.rob_tail;
            end
        end
    endtask

    task automatic set_in(logic fl, logic iv, logic [15:0] d, logic rr,
                          logic [2:0] tl, logic [1:0] rs, logic cv,
                          logic [3:0] crd, logic [2:0] ct);
        bif.flush        = fl;
        bif.inst_valid   = iv;
        bif.inst_data    = d;
        bif.rob_ready    = rr;
        bif.rob_tail     = tl;
        bif.rs_ready     = rs;
        bif.commit_valid = cv;
        bif.commit_rd    = crd;
        bif.commit_tag   = ct;
    endtask

    // Called at a falling edge with inputs applied; returns at the next one.
    task automatic step();
        #1;
        compute_exp();
        compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{1, 16'h1123, 1, 5, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 16'h0000, 1, 5, 3, 0, 0, 0, 1, 1, 2, 1, 3, 5, 0, 1};
        tbl[2]  = '{1, 16'h2412, 1, 6, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 16'h0000, 1, 6, 3, 0, 0, 0, 2, 0, 5, 1, 2, 6, 0, 1};
        tbl[4]  = '{1, 16'h7000, 1, 6, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{1, 16'h0312, 1, 6, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        tbl[6]  = '{0, 16'h0000, 1, 7, 3, 0, 0, 0, 1, 0, 5, 1, 2, 7, 0, 1};
        tbl[7]  = '{1, 16'h0110, 1, 7, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, 16'h0000, 1, 0, 3, 1, 1, 5, 1, 1, 1, 1, 0, 0, 0, 1};
        tbl[9]  = '{1, 16'h0011, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{0, 16'h0000, 1, 1, 3, 1, 1, 4, 1, 0, 0, 0, 0, 1, 0, 1};
        tbl[11] = '{1, 16'h0101, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{0, 16'h0000, 1, 2, 3, 0, 0, 0, 1, 0, 1, 0, 0, 2, 0, 1};
        tbl[13] = '{1, 16'h2000, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[14] = '{0, 16'h0000, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[15] = '{0, 16'h0000, 1, 3, 3, 0, 0, 0, 2, 0, 1, 0, 1, 3, 0, 1};

        model_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("reset_inst_ready", 32'(bif.inst_ready), 32'd1);
        chk("reset_iq_count", 32'(bif.iq_count), 32'd0);
        compute_exp();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: T1, T2, T4, T5 and a class-1 stall.
        for (int i = 0; i < 16; i++) begin
            set_in(0, tbl[i].iv, tbl[i].data, tbl[i].rr, tbl[i].tail,
                   tbl[i].rs, tbl[i].cv, tbl[i].crd, tbl[i].ctag);
            #1;
            chk($sformatf("v%0d_disp", i), 32'(bif.rs_dispatch),
                32'(tbl[i].x_disp));
            chk($sformatf("v%0d_s1r", i), 32'(bif.rs_src1_is_reg),
                32'(tbl[i].x_s1r));
            chk($sformatf("v%0d_s1", i), 32'(bif.rs_src1), 32'(tbl[i].x_s1));
            chk($sformatf("v%0d_s2r", i), 32'(bif.rs_src2_is_reg),
                32'(tbl[i].x_s2r));
            chk($sformatf("v%0d_s2", i), 32'(bif.rs_src2), 32'(tbl[i].x_s2));
            chk($sformatf("v%0d_dtag", i), 32'(bif.rs_dest_tag),
                32'(tbl[i].x_dtag));
            chk($sformatf("v%0d_bad", i), 32'(bif.bad_op), 32'(tbl[i].x_bad));
            chk($sformatf("v%0d_cnt", i), 32'(bif.iq_count),
                32'(tbl[i].x_cnt));
            step();
        end

        // T3: fill while ROB is stalled, then drain in order across the wrap.
        for (int k = 0; k < 4; k++) begin
            set_in(0, 1, {4'(k), 4'(k + 1), 4'(k), 4'(k)}, 0, 3'(k), 3,
                   0, 0, 0);
            step();
        end
        set_in(0, 1, 16'h0544, 0, 0, 3, 0, 0, 0);
        #1;
        chk("t3_full_ready", 32'(bif.inst_ready), 32'd0);
        chk("t3_full_count", 32'(bif.iq_count), 32'd4);
        chk("t3_stall_alloc", 32'(bif.rob_alloc), 32'd0);
        step();
        for (int k = 0; k < 4; k++) begin
            set_in(0, 1, {4'h1, 4'(k + 8), 4'h0, 4'h0}, 1, 3'(k + 4), 3,
                   0, 0, 0);
            #1;
            chk("t3_order_rd", 32'(bif.rob_rd), 32'(k + 1));
            step();
        end
        for (int k = 0; k < 6; k++) begin
            set_in(0, 0, 0, 1, 3'(k), 3, 0, 0, 0);
            step();
        end

        // T6: flush with three queued and several registers renamed.
        for (int k = 0; k < 3; k++) begin
            set_in(0, 1, {4'h0, 4'(k + 5), 4'h1, 4'h2}, 0, 0, 3, 0, 0, 0);
            step();
        end
        set_in(1, 1, 16'h0912, 1, 2, 3, 1, 1, 0);
        #1;
        chk("t6_flush_ready", 32'(bif.inst_ready), 32'd0);
        chk("t6_flush_disp", 32'(bif.rs_dispatch), 32'd0);
        step();
        set_in(0, 1, 16'h0A12, 0, 0, 3, 0, 0, 0);
        #1;
        chk("t6_count_after", 32'(bif.iq_count), 32'd0);
        step();
        set_in(0, 0, 0, 1, 4, 3, 0, 0, 0);
        #1;
        chk("t6_s1_is_reg", 32'(bif.rs_src1_is_reg), 32'd1);
        chk("t6_s2_is_reg", 32'(bif.rs_src2_is_reg), 32'd1);
        step();

        // Asynchronous reset during a stall with a dispatch pending.
        for (int k = 0; k < 2; k++) begin
            set_in(0, 1, 16'h0123, 0, 0, 3, 0, 0, 0);
            step();
        end
        set_in(0, 0, 0, 1, 6, 3, 0, 0, 0);
        #1;
        chk("rst_pre_alloc", 32'(bif.rob_alloc), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_alloc", 32'(bif.rob_alloc), 32'd0);
        chk("rst_disp", 32'(bif.rs_dispatch), 32'd0);
        chk("rst_count", 32'(bif.iq_count), 32'd0);
        chk("rst_ready", 32'(bif.inst_ready), 32'd1);
        chk("rst_src1", 32'(bif.rs_src1), 32'd0);
        model_reset();
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] crd;
            crd = 4'($urandom_range(15));
            set_in(($urandom_range(39) == 0),
                   ($urandom_range(2) != 0),
                   {4'($urandom_range(5)), 12'($urandom)},
                   ($urandom_range(3) != 0),
                   3'($urandom),
                   2'($urandom),
                   1'($urandom),
                   crd,
                   ($urandom_range(1) == 0) ? mtag[crd] : 3'($urandom));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
